// File: rtl/fullsub_mux_row_if.sv
// Operand/result bundle for one subtract/restore row of a restoring array divider.
// The master drives the operands and the restore select. The slave returns the selected result and the borrow.
interface fullsub_mux_row_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             Ctrl;
    logic [WIDTH-1:0] Mout;
    logic             Bout;

    modport master (
        output A,
        output B,
        output Bin,
        output Ctrl,
        input  Mout,
        input  Bout
    );

    modport slave (
        input  A,
        input  B,
        input  Bin,
        input  Ctrl,
        output Mout,
        output Bout
    );
endinterface

// File: rtl/fullsub_mux_row.sv
// One row of a restoring array divider: computes A - B - Bin with a rippled borrow.
// It outputs either the difference or the untouched A (restore), optionally registered.
module fullsub_mux_row #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fullsub_mux_row_if.slave      io_bus
);

    // Ripple-borrow subtractor; returns {borrow_out, difference}.
    function automatic logic [WIDTH:0] sub_row(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             bin
    );
        logic [WIDTH:0]   borrow;
        logic [WIDTH-1:0] d;
        borrow    = {(WIDTH+1){1'b0}};
        d         = {WIDTH{1'b0}};
        borrow[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
            d[i]        = a[i] ^ b[i] ^ borrow[i];
            borrow[i+1] = (~a[i] & b[i]) | (~a[i] & borrow[i]) | (b[i] & borrow[i]);
        end
        return {borrow[WIDTH], d};
    endfunction

    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_mout;
    logic             w_bout;

    // Subtract, then let Ctrl choose restore (A) or difference; Ctrl never touches the borrow.
    always_comb begin
        w_sub  = sub_row(io_bus.A, io_bus.B, io_bus.Bin);
        w_bout = w_sub[WIDTH];
        if (io_bus.Ctrl) begin
            w_mout = io_bus.A;
        end else begin
            w_mout = w_sub[WIDTH-1:0];
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] r_mout;
            logic             r_bout;

            // Single-stage output register; asynchronous clear discards any in-flight result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mout <= {WIDTH{1'b0}};
                    r_bout <= 1'b0;
                end else begin
                    r_mout <= w_mout;
                    r_bout <= w_bout;
                end
            end

            assign io_bus.Mout = r_mout;
            assign io_bus.Bout = r_bout;
        end else begin : g_comb
            // The clock and reset have no function in the purely combinational build.
            logic w_unused;
            assign w_unused    = ^{clk, rst_n};
            assign io_bus.Mout = w_mout;
            assign io_bus.Bout = w_bout;
        end
    endgenerate

endmodule

// File: tb/tb_fullsub_mux_row.sv
// Self-checking bench for fullsub_mux_row: a registered 1-bit cell, a registered 8-bit row and a combinational 4-bit row.
// The expected values come from plain unsigned arithmetic on A - B - Bin.
module tb_fullsub_mux_row;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fullsub_mux_row_if #(.WIDTH(1)) if1 ();
    fullsub_mux_row_if #(.WIDTH(8)) if8 ();
    fullsub_mux_row_if #(.WIDTH(4)) if4 ();

    fullsub_mux_row #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (.clk(clk), .rst_n(rst_n), .io_bus(if1));
    fullsub_mux_row #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (.clk(clk), .rst_n(rst_n), .io_bus(if8));
    fullsub_mux_row #(.WIDTH(4), .REGISTERED(1'b0)) u_w4 (.clk(clk), .rst_n(rst_n), .io_bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout, mout} for a w-bit row, computed with signed integer arithmetic.
    function automatic logic [32:0] ref_row(input int w, input int a, input int b, input int bin, input int ctrl);
        int full;
        int mask;
        logic [31:0] m;
        full = a - b - bin;
        mask = (1 << w) - 1;
        m = (ctrl != 0) ? 32'(a) : 32'(full & mask);
        return {(full < 0) ? 1'b1 : 1'b0, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive1(input int a, input int b, input int bin, input int ctrl);
        if1.A = 1'(a); if1.B = 1'(b); if1.Bin = 1'(bin); if1.Ctrl = 1'(ctrl);
    endtask

    task automatic drive8(input int a, input int b, input int bin, input int ctrl);
        if8.A = 8'(a); if8.B = 8'(b); if8.Bin = 1'(bin); if8.Ctrl = 1'(ctrl);
    endtask

    task automatic drive4(input int a, input int b, input int bin, input int ctrl);
        if4.A = 4'(a); if4.B = 4'(b); if4.Bin = 1'(bin); if4.Ctrl = 1'(ctrl);
    endtask

    task automatic check1(input string tag, input int a, input int b, input int bin, input int ctrl);
        logic [32:0] e;
        e = ref_row(1, a, b, bin, ctrl);
        check({tag, ".w1_mout"}, 32'(if1.Mout), e[31:0]);
        check({tag, ".w1_bout"}, 32'(if1.Bout), 32'(e[32]));
    endtask

    task automatic check8(input string tag, input int a, input int b, input int bin, input int ctrl);
        logic [32:0] e;
        e = ref_row(8, a, b, bin, ctrl);
        check({tag, ".w8_mout"}, 32'(if8.Mout), e[31:0]);
        check({tag, ".w8_bout"}, 32'(if8.Bout), 32'(e[32]));
    endtask

    task automatic check4(input string tag, input int a, input int b, input int bin, input int ctrl);
        logic [32:0] e;
        e = ref_row(4, a, b, bin, ctrl);
        check({tag, ".w4_mout"}, 32'(if4.Mout), e[31:0]);
        check({tag, ".w4_bout"}, 32'(if4.Bout), 32'(e[32]));
    endtask

    initial begin
        int a1, b1, c1, k1, a8, b8, c8, k8, a4, b4, c4, k4;
        logic [7:0] sweep_m;
        logic [7:0] sweep_b;
        total = 0;
        bad   = 0;
        sweep_m = 8'b1001_0110;
        sweep_b = 8'b1000_1110;

        // Reset with nonzero operands: registered outputs must be held at zero.
        rst_n = 1'b0;
        drive1(0, 1, 0, 0);
        drive8(8'h17, 8'h35, 0, 0);
        drive4(4'h9, 4'h3, 1, 0);
        #1;
        check("rst.w1_mout", 32'(if1.Mout), 32'd0);
        check("rst.w1_bout", 32'(if1.Bout), 32'd0);
        check("rst.w8_mout", 32'(if8.Mout), 32'd0);
        check("rst.w8_bout", 32'(if8.Bout), 32'd0);
        check4("rst_comb", 4'h9, 4'h3, 1, 0);
        check("rst_comb.w4_mout_const", 32'(if4.Mout), 32'h5);
        @(posedge clk); #1;
        check("rst_hold.w8_mout", 32'(if8.Mout), 32'd0);
        check("rst_hold.w8_bout", 32'(if8.Bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth-table sweep with Ctrl=0, and again with Ctrl=1 (restore).
        for (int ctrl = 0; ctrl < 2; ctrl++) begin
            for (int v = 0; v < 8; v++) begin
                drive1((v >> 2) & 1, (v >> 1) & 1, v & 1, ctrl);
                @(posedge clk); #1;
                check1($sformatf("sweep_c%0d_%0d", ctrl, v), (v >> 2) & 1, (v >> 1) & 1, v & 1, ctrl);
                check($sformatf("sweep_tbl_c%0d_%0d.bout", ctrl, v), 32'(if1.Bout), 32'(sweep_b[v]));
                if (ctrl == 0) begin
                    check($sformatf("sweep_tbl_%0d.mout", v), 32'(if1.Mout), 32'(sweep_m[v]));
                end else begin
                    check($sformatf("sweep_tbl_r%0d.mout", v), 32'(if1.Mout), 32'((v >> 2) & 1));
                end
                @(negedge clk);
            end
        end

        // WIDTH=8 directed points, including wraparound and the all-ones boundaries.
        drive8(8'h35, 8'h17, 0, 0); @(posedge clk); #1;
        check("d8a.mout", 32'(if8.Mout), 32'h1E); check("d8a.bout", 32'(if8.Bout), 32'd0);
        @(negedge clk);
        drive8(8'h17, 8'h35, 0, 0); @(posedge clk); #1;
        check("d8b.mout", 32'(if8.Mout), 32'hE2); check("d8b.bout", 32'(if8.Bout), 32'd1);
        @(negedge clk);
        drive8(8'h17, 8'h35, 0, 1); @(posedge clk); #1;
        check("d8c.mout", 32'(if8.Mout), 32'h17); check("d8c.bout", 32'(if8.Bout), 32'd1);
        @(negedge clk);
        drive8(8'h00, 8'h00, 1, 0); @(posedge clk); #1;
        check("d8d.mout", 32'(if8.Mout), 32'hFF); check("d8d.bout", 32'(if8.Bout), 32'd1);
        @(negedge clk);
        drive8(8'hFF, 8'hFF, 1, 0); @(posedge clk); #1;
        check("d8e.mout", 32'(if8.Mout), 32'hFF); check("d8e.bout", 32'(if8.Bout), 32'd1);
        @(negedge clk);
        drive8(8'hA5, 8'hA5, 0, 0); @(posedge clk); #1;
        check("d8f.mout", 32'(if8.Mout), 32'h00); check("d8f.bout", 32'(if8.Bout), 32'd0);
        @(negedge clk);

        // Combinational WIDTH=4 row: the result must appear without any clock edge.
        drive4(4'h9, 4'h3, 1, 0); #1;
        check("c4.mout", 32'(if4.Mout), 32'h5); check("c4.bout", 32'(if4.Bout), 32'd0);
        drive4(4'h0, 4'h0, 1, 0); #1;
        check("c4z.mout", 32'(if4.Mout), 32'hF); check("c4z.bout", 32'(if4.Bout), 32'd1);

        // Randomized traffic on all three instances: one result per cycle, each checked one cycle later.
        for (int n = 0; n < 200; n++) begin
            a1 = int'($urandom_range(0, 1));   b1 = int'($urandom_range(0, 1));
            c1 = int'($urandom_range(0, 1));   k1 = int'($urandom_range(0, 1));
            a8 = int'($urandom_range(0, 255)); b8 = int'($urandom_range(0, 255));
            c8 = int'($urandom_range(0, 1));   k8 = int'($urandom_range(0, 1));
            a4 = int'($urandom_range(0, 15));  b4 = int'($urandom_range(0, 15));
            c4 = int'($urandom_range(0, 1));   k4 = int'($urandom_range(0, 1));
            drive1(a1, b1, c1, k1);
            drive8(a8, b8, c8, k8);
            drive4(a4, b4, c4, k4);
            #1;
            check4($sformatf("rnd%0d", n), a4, b4, c4, k4);
            @(posedge clk); #1;
            check1($sformatf("rnd%0d", n), a1, b1, c1, k1);
            check8($sformatf("rnd%0d", n), a8, b8, c8, k8);
            @(negedge clk);
        end

        // Mid-stream reset: nonzero results in flight, then rst_n pulled low between edges.
        drive8(8'h35, 8'h17, 0, 0);
        drive1(1, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst.w8_mout", 32'(if8.Mout), 32'h1E);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.w8_mout", 32'(if8.Mout), 32'd0);
        check("async_rst.w8_bout", 32'(if8.Bout), 32'd0);
        check("async_rst.w1_mout", 32'(if1.Mout), 32'd0);
        drive8(8'h17, 8'h35, 0, 0);
        @(posedge clk); #1;
        check("rst_low.w8_mout", 32'(if8.Mout), 32'd0);
        check("rst_low.w8_bout", 32'(if8.Bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive8(8'h40, 8'h01, 1, 0);
        @(posedge clk); #1;
        check8("post_rst", 8'h40, 8'h01, 1, 0);
        check("post_rst.w8_mout_const", 32'(if8.Mout), 32'h3E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fullsub_mux_row.md
Name: fullsub_mux_row

Overview:
- Restoring-division subtract/restore cell row.
- Computes A − B − Bin across WIDTH bits with a rippled borrow.
- Outputs either the difference or the unmodified A (restore), selected by Ctrl.
- Outputs are registered. One instance forms one row of the array divider; WIDTH=1 gives the single-bit full-subtractor/mux cell.

Parameters:
- WIDTH, 1: operand width in bits (≥1); borrow ripples LSB→MSB.
- REGISTERED, 1: 1 = outputs registered (latency 1 clk); 0 = outputs purely combinational (clk/rst_n unused).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- A  input  WIDTH  minuend (partial remainder bits).
- B  input  WIDTH  subtrahend (divisor bits).
- Bin  input  1  borrow-in into bit 0.
- Ctrl  input  1  restore select, shared by all bits of the row; 1 = pass A, 0 = pass difference.
- Mout  output  WIDTH  selected result per bit.
- Bout  output  1  borrow-out of MSB.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Per bit i, with b0 = Bin:
  - D[i] = A[i] ^ B[i] ^ b[i]
  - b[i+1] = (~A[i] & B[i]) | (~A[i] & b[i]) | (B[i] & b[i])
- Bout = b[WIDTH]. This equals 1 exactly when A < B + Bin (unsigned).
- Mout[i] = Ctrl ? A[i] : D[i].
- Ctrl does not affect Bout; the borrow chain is always computed from A, B and Bin.
- Arithmetic is unsigned and modulo 2^WIDTH: {Bout, D} = A − B − Bin with Bout as the wrap/borrow flag. No saturation.
- REGISTERED=1:
  - All inputs are sampled on the rising clk edge; Mout/Bout update on that edge.
  - Latency is exactly 1 cycle, throughput 1 result/cycle, no handshake. Every cycle's inputs produce a result.
- Reset (REGISTERED=1):
  - rst_n low clears Mout to 0 and Bout to 0 immediately, independent of clk.
  - While rst_n is low, outputs hold at 0 regardless of inputs.
  - The first rising edge with rst_n high loads the result of the inputs present at that edge.
  - Reset asserted mid-stream discards the in-flight result.
- REGISTERED=0: outputs follow inputs combinationally; rst_n has no effect.
- Boundaries:
  - A=B, Bin=0 → D=0, Bout=0.
  - A=0, B=0, Bin=1 → D=all ones, Bout=1.
  - A=all ones, B=all ones, Bin=1 → D=all ones, Bout=1.
  - Borrow propagates through the full width in one cycle; there is no internal pipelining.
- No X propagation from unused logic: with known inputs, outputs are always known after reset.

Test Plan:
- WIDTH=1, Ctrl=0, sweep {A,B,Bin} 000..111 one per cycle. Expect (Mout,Bout) one cycle later:
  - 000→(0,0)
  - 001→(1,1)
  - 010→(1,1)
  - 011→(0,1)
  - 100→(1,0)
  - 101→(0,0)
  - 110→(0,0)
  - 111→(1,1)
- WIDTH=1, Ctrl=1, same sweep → Mout equals A of the previous cycle; Bout values identical to the Ctrl=0 sweep.
- WIDTH=8, Ctrl=0: A=0x35, B=0x17, Bin=0 → Mout=0x1E, Bout=0. Then A=0x17, B=0x35, Bin=0 → Mout=0xE2, Bout=1.
- WIDTH=8, Ctrl=1: A=0x17, B=0x35 → Mout=0x17, Bout=1. Also A=0x00, B=0x00, Bin=1, Ctrl=0 → Mout=0xFF, Bout=1.
- Reset: drive nonzero results for several cycles, then pull rst_n low between clock edges → Mout=0, Bout=0 immediately. Outputs stay 0 while low. After release, the next edge yields the current-input result.
- REGISTERED=0, WIDTH=4: A=0x9, B=0x3, Bin=1, Ctrl=0 → Mout=0x5, Bout=0 within the same time step, with no clock.
